// File: rtl/ir_tx_encoder.sv
// ir_tx_encoder: pulse-distance IR frame serialiser (leader, LSB-first bit cells, stop mark).
// Define IR_CARRIER_EN to gate marks with a CARRIER_HALF-cycle carrier; otherwise o_ir is the baseband envelope.
module ir_tx_encoder #(
  parameter int DATA_BITS    = 32,
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ir,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int UW = $clog2(UNIT_CYCLES);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} state_t;
  state_t               st_q, st_d;
  logic [UW-1:0]        ucnt_q, ucnt_d;
  logic [4:0]           units_q, units_d, tgt;
  logic [BW-1:0]        bits_q, bits_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 ir_q, ir_d, busy_q, busy_d, done_q, done_d;
  logic                 wrap, last, mark_d;
  always_comb begin
    tgt     = st_q == LEAD_MARK ? 5'd16 : st_q == LEAD_SPACE ? 5'd8 :
              (st_q == BIT_SPACE && sh_q[0]) ? 5'd3 : 5'd1;
    wrap    = ucnt_q == UW'(UNIT_CYCLES - 1);
    last    = wrap && units_q == tgt - 5'd1;
    st_d    = st_q;
    ucnt_d  = wrap ? '0 : ucnt_q + 1'b1;
    units_d = units_q + {4'd0, wrap};
    bits_d  = bits_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (st_q == IDLE) begin
      ucnt_d  = '0;
      units_d = '0;
    end else if (last) begin
      ucnt_d  = '0;
      units_d = '0;
      case (st_q)
        LEAD_MARK:  st_d = LEAD_SPACE;
        LEAD_SPACE: st_d = BIT_MARK;
        BIT_MARK:   st_d = BIT_SPACE;
        BIT_SPACE: begin
          sh_d   = sh_q >> 1;
          bits_d = bits_q + 1'b1;
          st_d   = bits_q == BW'(DATA_BITS - 1) ? STOP_MARK : BIT_MARK;
        end
        default: begin
          st_d   = IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      endcase
    end
    // A start held through the stop mark chains the next frame with no idle cycle.
    if ((st_q == IDLE || (st_q == STOP_MARK && last)) && i_start) begin
      st_d    = LEAD_MARK;
      sh_d    = i_data;
      bits_d  = '0;
      busy_d  = 1'b1;
      ucnt_d  = '0;
      units_d = '0;
    end
    mark_d = st_d == LEAD_MARK || st_d == BIT_MARK || st_d == STOP_MARK;
  end
`ifdef IR_CARRIER_EN
  localparam int CW = $clog2(CARRIER_HALF + 1);
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          car_q, car_d;
  always_comb begin
    car_d  = st_d == IDLE ? 1'b0 : (mark_d && st_d != st_q) ? 1'b1 :
             ccnt_q == CW'(CARRIER_HALF - 1) ? ~car_q : car_q;
    ccnt_d = (st_d == IDLE || st_d != st_q || ccnt_q == CW'(CARRIER_HALF - 1)) ? '0 : ccnt_q + 1'b1;
    ir_d   = mark_d & car_d;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      ccnt_q <= '0;
      car_q  <= 1'b0;
    end else begin
      ccnt_q <= ccnt_d;
      car_q  <= car_d;
    end
`else
  assign ir_d = mark_d;
`endif
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      st_q    <= IDLE;
      ucnt_q  <= '0;
      units_q <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      ir_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      ucnt_q  <= ucnt_d;
      units_q <= units_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      ir_q    <= ir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign o_ir   = ir_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
endmodule
